// File: rtl/timer_pkg.sv
// Shared definitions for the timer counter stage: TCR field layout, prescaler widths
// and the helper that turns a prescale select into its terminal divider count.
package timer_pkg;

   localparam int TCR_WIDTH = 8;
   localparam int EN_BIT    = 0;
   localparam int DIR_BIT   = 1;
   localparam int CKS_LSB   = 2;
   localparam int CKS_MSB   = 4;
   localparam int CKS_WIDTH = 3;
   localparam int DIV_WIDTH = 7;

   typedef struct packed {
      logic [2:0]           rsvd;
      logic [CKS_WIDTH-1:0] cks;
      logic                 dir;
      logic                 en;
   } tcr_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Last divider value of a 2^cks period; the extra bit lets cks = 7 reach 127.
   function automatic logic [DIV_WIDTH-1:0] div_terminal(input logic [CKS_WIDTH-1:0] cks);
      logic [DIV_WIDTH:0] period;
      period = (DIV_WIDTH + 1)'(1) << cks;
      return DIV_WIDTH'(period - (DIV_WIDTH + 1)'(1));
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: free-running divider on the system clock that emits a one-cycle
// tick every 2^cks enabled, non-halted cycles.
module timer_prescaler
   import timer_pkg::*;
(
   input  logic                 i_clk_sys,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic [CKS_WIDTH-1:0] i_cks,
   input  logic                 i_clear,
   input  logic                 i_halt,
   output logic                 o_tick
);

   logic [DIV_WIDTH-1:0] div_cnt_q;
   logic [DIV_WIDTH-1:0] div_cnt_d;

   assign o_tick = i_en && !i_halt && (div_cnt_q == div_terminal(i_cks));

   always_comb begin
      // NOTE: default assigned first so every path drives div_cnt_d; no latch is inferred.
      div_cnt_d = div_cnt_q;
      if (!i_en || i_clear) begin
         div_cnt_d = '0;
      end else if (i_halt) begin
         div_cnt_d = div_cnt_q;
      end else if (o_tick) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (!i_rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/timer_counter.sv
// Timer counter stage: prescaled up/down counter with load and one-cycle wrap pulses.
// Define TIMER_DBG_HALT_EN to add the i_dbg_halt debug-freeze input.
module timer_counter
   import timer_pkg::*;
#(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 i_clk_sys,
   input  logic                 i_rst_n,
   input  logic [TCR_WIDTH-1:0] i_tcr,
   input  logic [CNT_WIDTH-1:0] i_tdr,
   input  logic                 i_load,
`ifdef TIMER_DBG_HALT_EN
   input  logic                 i_dbg_halt,
`endif
   output logic [CNT_WIDTH-1:0] o_tcnt,
   output logic                 o_ovf,
   output logic                 o_udf
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                 en;
   dir_e                 dir;
   logic [CKS_WIDTH-1:0] cks;
   logic [CKS_WIDTH-1:0] cks_q;
   logic [CKS_WIDTH-1:0] cks_d;
   logic                 halt;
   logic                 tick;
   logic                 clear;
   logic                 unused_rsvd;
   logic [CNT_WIDTH-1:0] tcnt_q;
   logic [CNT_WIDTH-1:0] tcnt_d;
   logic                 ovf_q;
   logic                 ovf_d;
   logic                 udf_q;
   logic                 udf_d;

   assign en          = i_tcr[EN_BIT];
   assign dir         = dir_e'(i_tcr[DIR_BIT]);
   assign cks         = i_tcr[CKS_MSB:CKS_LSB];
   assign unused_rsvd = ^i_tcr[TCR_WIDTH-1:CKS_MSB+1];

`ifdef TIMER_DBG_HALT_EN
   assign halt = i_dbg_halt;
`else
   assign halt = 1'b0;
`endif

   // A new prescale select restarts the period from zero on the following cycle.
   assign cks_d = cks;
   assign clear = i_load || (cks != cks_q);

   timer_prescaler u_prescaler (
      .i_clk_sys (i_clk_sys),
      .i_rst_n   (i_rst_n),
      .i_en      (en),
      .i_cks     (cks),
      .i_clear   (clear),
      .i_halt    (halt),
      .o_tick    (tick)
   );

   always_comb begin
      tcnt_d = tcnt_q;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
      if (i_load) begin
         tcnt_d = i_tdr;
      end else if (tick) begin
         if (dir == DIR_UP) begin
            tcnt_d = tcnt_q + CNT_ONE;
            ovf_d  = (tcnt_q == CNT_MAX);
         end else begin
            tcnt_d = tcnt_q - CNT_ONE;
            udf_d  = (tcnt_q == '0);
         end
      end
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cks_q  <= '0;
         tcnt_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         cks_q  <= cks_d;
         tcnt_q <= tcnt_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   assign o_tcnt = tcnt_q;
   assign o_ovf  = ovf_q;
   assign o_udf  = udf_q;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counter stage directly downstream of the timer control register; consumes its 8-bit control byte (TCR) plus the data register value (TDR).
- Produces the running count (TCNT) and one-cycle overflow/underflow pulses.
- Pulses feed the interrupt/status stage.
- Contains the clock prescaler and the up/down counter. All logic runs on the system clock; no derived clocks.

Parameters:
- CNT_WIDTH, 8, width of TDR and TCNT.

Ports:
- i_clk_sys  input  1  system clock, rising-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_tcr  input  8  control byte from the control register (field map below).
- i_tdr  input  CNT_WIDTH  load value.
- i_load  input  1  one-cycle load strobe from the register block.
- i_dbg_halt  input  1  debug freeze; present only with TIMER_DBG_HALT_EN.
- o_tcnt  output  CNT_WIDTH  current count.
- o_ovf  output  1  one-cycle pulse on up-count wrap from max to 0.
- o_udf  output  1  one-cycle pulse on down-count wrap from 0 to max.

Behaviour:
- Interface: one clock, i_clk_sys. Reset i_rst_n is asynchronous, active-low.
- TCR field map:
  - bit0 EN: count enable.
  - bit1 DIR: 0 = up, 1 = down.
  - bits4:2 CKS: prescale select, divisor 2^CKS, range 1..128.
  - bits7:5 reserved, ignored.
- Reset state: o_tcnt = 0, o_ovf = 0, o_udf = 0, prescaler count = 0.
- Prescaler:
  - 7-bit div_cnt increments each cycle while EN = 1.
  - tick = EN and (div_cnt == 2^CKS - 1); on tick, div_cnt returns to 0.
  - CKS = 0 gives a tick every cycle.
  - div_cnt clears to 0 when EN = 0, on i_load, and in the cycle after any CKS change (CKS registered for change detect).
- Counter priority, highest first:
  1. i_load: o_tcnt <= i_tdr on the next edge; no flag; any tick in the same cycle is discarded.
  2. tick with DIR = 0: o_tcnt + 1. At all-ones, wraps to 0 and o_ovf = 1 for exactly one cycle, registered on the same edge as the wrap.
  3. tick with DIR = 1: o_tcnt - 1. At 0, wraps to all-ones and o_udf = 1 for one cycle.
  4. Otherwise hold.
- Flags default to 0 every cycle; they are never asserted simultaneously.
- Latency:
  - First tick arrives 2^CKS cycles after EN rises.
  - o_tcnt changes on the edge at the end of the tick cycle.
- DIR change mid-count takes effect at the next tick; no glitch, no flag.
- EN deassert freezes o_tcnt at its current value; i_load still works while EN = 0.
- Reset mid-count returns all state to reset values asynchronously. First count after release needs a full prescale period.
- Arithmetic is modulo 2^CNT_WIDTH; no saturation.

Optional Feature:
- Macro: TIMER_DBG_HALT_EN.
- Defined:
  - i_dbg_halt port exists.
  - While i_dbg_halt = 1, div_cnt and o_tcnt hold and ticks are suppressed.
  - i_load still has effect.
  - No flags fire during halt.
  - Counting resumes from the held div_cnt on release.
- Undefined: port absent; behaviour as if halt = 0.

Decomposition:
- Shared package timer_pkg:
  - TCR bit-index localparams (EN_BIT, DIR_BIT, CKS_LSB/CKS_MSB).
  - CKS_WIDTH = 3, DIV_WIDTH = 7.
  - Packed struct tcr_t {rsvd[2:0], cks[2:0], dir, en}.
  - Enum dir_e {DIR_UP, DIR_DOWN}.
- One sub-module, timer_prescaler:
  - Inputs: clock, reset, en, cks, clear (load or CKS change), halt.
  - Output: tick.
  - Counter logic stays in timer_counter.

Test Plan:
- Reset then TCR = 0x01 (EN, up, CKS = 0), i_tdr = 0xFD, i_load pulse → o_tcnt = 0xFD, 0xFE, 0xFF, 0x00; o_ovf = 1 only in the 0x00 cycle.
- TCR = 0x03 (down), load 0x01 → o_tcnt = 0x00 then 0xFF; o_udf = 1 for one cycle at 0xFF; o_ovf stays 0.
- TCR = 0x0D (CKS = 3, up) from 0 → o_tcnt increments every 8 cycles; after 64 cycles o_tcnt = 8.
- i_load with i_tdr = 0x80 in the same cycle as a tick → o_tcnt = 0x80, no increment, no flag; next increment 2^CKS cycles later.
- Count to 0x10, clear EN for 20 cycles, set again → o_tcnt holds 0x10, then resumes. Assert i_rst_n low mid-count → o_tcnt = 0 immediately, flags 0.
- With TIMER_DBG_HALT_EN: CKS = 2, i_dbg_halt high for 10 cycles mid-period → o_tcnt frozen. The remaining prescale count completes after release; no flags during halt.
